// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined CPU front end.
package cpu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      DRAIN,
      DONE,
      FAULT
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0020;
   localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag.
// Flush wins over load; with neither asserted the register holds.
module if_id_register
   import cpu_pkg::*;
#(
   parameter logic [31:0] NOP = NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc4_in,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         instr <= NOP;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (load) begin
         instr <= instr_in;
         pc4   <= pc4_in;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, strobes instruction memory,
// fills IF/ID, applies stall/branch requests and drains at program end.
module fetch_controller
   import cpu_pkg::*;
#(
   parameter logic [31:0] PC_RESET     = 32'd0,
   parameter logic [31:0] PROG_END     = 32'd80,
   parameter int          DRAIN_CYCLES = 4,
   parameter logic [31:0] NOP          = NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] instruction_in,
   output logic [31:0] imem_address,
   output logic        imem_load,
   output logic [31:0] pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        running,
   output logic        done,
   output logic        fault
);

   localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DRAIN_CYCLES - 1);

   fetch_state_t     state, next_state;
   logic [31:0]      pc_next;
   logic [31:0]      pc_plus4;
   logic [CNT_W-1:0] drain_cnt, cnt_next;
   logic             ifid_load, ifid_flush;
   logic             target_ok;

   assign pc_plus4  = pc + INSTR_BYTES;
   assign target_ok = (branch_target[1:0] == 2'b00) && (branch_target < PROG_END);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= PC_RESET;
         drain_cnt <= '0;
      end else begin
         state     <= next_state;
         pc        <= pc_next;
         drain_cnt <= cnt_next;
      end
   end

   // Branch beats stall beats advance; an illegal target freezes everything in FAULT.
   always_comb begin
      next_state = state;
      pc_next    = pc;
      cnt_next   = drain_cnt;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               next_state = LOAD;
               pc_next    = PC_RESET;
            end
         end
         LOAD: next_state = RUN;
         RUN: begin
            if (branch_taken) begin
               if (target_ok) begin
                  pc_next    = branch_target;
                  ifid_flush = 1'b1;
               end else begin
                  next_state = FAULT;
               end
            end else if (!stall) begin
               ifid_load = 1'b1;
               pc_next   = pc_plus4;
               if (pc_plus4 >= PROG_END) begin
                  next_state = DRAIN;
                  cnt_next   = '0;
               end
            end
         end
         DRAIN: begin
            if (branch_taken) begin
               if (target_ok) begin
                  next_state = RUN;
                  pc_next    = branch_target;
                  ifid_flush = 1'b1;
                  cnt_next   = '0;
               end else begin
                  next_state = FAULT;
               end
            end else begin
               ifid_flush = 1'b1;
               if (!stall) begin
                  if (drain_cnt == LAST_CNT) next_state = DONE;
                  else cnt_next = drain_cnt + CNT_W'(1);
               end
            end
         end
         FAULT: next_state = FAULT;
         default: next_state = IDLE;
      endcase
   end

   if_id_register #(.NOP(NOP)) u_if_id (
      .clk      (clk),
      .reset    (reset),
      .load     (ifid_load),
      .flush    (ifid_flush),
      .instr_in (instruction_in),
      .pc4_in   (pc_plus4),
      .instr    (if_id_instr),
      .pc4      (if_id_pc4),
      .valid    (if_id_valid)
   );

   assign imem_address = pc;
   assign imem_load    = (state == LOAD);
   assign running      = (state == LOAD) || (state == RUN) || (state == DRAIN);
   assign done         = (state == DONE);
   assign fault        = (state == FAULT);

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the instruction-fetch stage: owns the program counter, drives the instruction memory's address and load strobe, and fills the IF/ID pipeline register. It applies stall and branch-redirect requests from the hazard/branch logic and inserts `add $zero,$zero,$zero` bubbles (32'h00000020). When the program ends it drains the pipeline and signals completion. It sits between the top-level start control, the instruction memory, and the IF/ID stage of the pipelined CPU.

## Interface
- `PC_RESET`, 32'd0: first fetch address.
- `PROG_END`, 32'd80: byte address one past the last instruction; equals the instruction memory size.
- `DRAIN_CYCLES`, 4: bubble cycles issued after the last fetch so in-flight instructions retire.
- `NOP`, 32'h00000020: bubble encoding.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse; begins a run from IDLE or DONE.
- `stall`  in  1  hazard unit: hold PC and IF/ID this cycle.
- `branch_taken`  in  1  redirect request from EX.
- `branch_target`  in  32  redirect byte address.
- `instruction_in`  in  32  combinational read data from instruction memory.
- `imem_address`  out  32  equals `pc` in every state.
- `imem_load`  out  1  drives the memory's `startin`; high only in LOAD.
- `pc`  out  32  current fetch address.
- `if_id_instr`  out  32  IF/ID instruction register.
- `if_id_pc4`  out  32  IF/ID PC+4 register.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `running`  out  1  high in LOAD, RUN and DRAIN.
- `done`  out  1  high in DONE.
- `fault`  out  1  high in FAULT.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE, FAULT.
- IDLE:
  - `pc`=PC_RESET; IF/ID holds NOP, valid=0.
  - `start` -> LOAD.
- LOAD: `imem_load`=1 for exactly one cycle, then RUN.
- RUN priority per cycle is branch_taken > stall > advance.
  - Branch: if target[1:0]≠0 or target≥PROG_END -> FAULT, with PC and IF/ID unchanged. Otherwise `pc`<=target, IF/ID<=NOP, valid<=0.
  - Stall: `pc` and all IF/ID registers hold.
  - Advance: `if_id_instr`<=instruction_in, `if_id_pc4`<=pc+4, valid<=1, `pc`<=pc+4. If pc+4≥PROG_END, go to DRAIN with drain counter=0.
- DRAIN:
  - Each cycle: IF/ID<=NOP, valid<=0.
  - Counter increments unless `stall`; counter reaching DRAIN_CYCLES-1 -> DONE.
  - A legal branch returns to RUN at the target with the counter cleared. An illegal branch -> FAULT.
- DONE:
  - `done`=1; PC and IF/ID hold, IF/ID being NOP with valid=0.
  - `start` -> LOAD with `pc`=PC_RESET.
- FAULT: `fault`=1; everything holds until `reset`.
- `start` is ignored in LOAD, RUN, DRAIN and FAULT.
- Arithmetic: 32-bit unsigned; pc+4 wraps mod 2^32. The PROG_END check prevents wrap in practice.

## Timing
- Reset, applied at any time, including mid-run: next edge gives IDLE, `pc`=PC_RESET, `if_id_instr`=NOP, `if_id_pc4`=0, `if_id_valid`=0, `imem_load`=0, `running`=`done`=`fault`=0.
- `start` in cycle 0: LOAD in cycle 1, RUN in cycle 2. The first instruction is latched at the end of cycle 2 and visible in IF/ID in cycle 3.
- Fetch latency: one cycle from `imem_address` to IF/ID. Throughput: one instruction per unstalled cycle.
- `imem_address` is combinational from the `pc` register. `instruction_in` is sampled at the same edge.
- Stall and branch in the same cycle: branch wins.
- All IF/ID registers and state update only on the rising `clk` edge. Outputs are registered except `imem_address`, `running`, `done`, `fault` and `imem_load`, which decode the state/pc registers.

## Structure
- Shared package `cpu_pkg`:
  - state enum {IDLE, LOAD, RUN, DRAIN, DONE, FAULT}
  - `NOP_INSTR` = 32'h00000020
  - `INSTR_BYTES` = 4
- Natural sub-module: `if_id_register`. It holds instr/pc4/valid and has load-enable (advance), flush (load NOP, valid=0) and hold. The FSM and PC logic stay in `fetch_controller`.

## Test plan
- Reset, then `start`; no stall or branch, PROG_END=80 → 20 instructions appear in IF/ID at pc4=4..80 on consecutive cycles. Then 4 NOP cycles, then `done`=1.
- `stall` for 3 cycles while pc=20 → `pc` stays 20 and IF/ID is unchanged for 3 cycles. Fetching resumes at 20.
- `branch_taken` with target=8 while pc=24, with `stall` also high → next cycle `pc`=8, IF/ID=NOP, valid=0. The following cycle latches the instruction at 8 with pc4=12.
- `branch_taken` with target=6, then, after reset, with target=80 → `fault`=1 in each case. `pc` is unchanged, and `start` is ignored until `reset`.
- `branch_taken` with target=0 in DRAIN cycle 2 → returns to RUN at pc=0, and the drain counter restarts at the next program end.
- `reset` asserted in RUN at pc=36 → next cycle is IDLE with all outputs at reset values. `start` then reloads and fetches from 0.
